// File: rtl/conv2d_opt_mem_sched.sv
// Request sequencer for one optimized 2D convolution job: weight reads first, then
// IFM reads interleaved with OFM writes on a single shared, credit-limited request port.
module conv2d_opt_mem_sched #(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned WT_DIM    = 3,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       fm_dim,
  input  logic [AWIDTH-1:0] wt_base,
  input  logic [AWIDTH-1:0] ifm_base,
  input  logic [AWIDTH-1:0] ofm_base,
  output logic              idle,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [AWIDTH-1:0] req_addr,
  output logic              req_write,
  input  logic              rresp_valid,
  input  logic              ofm_valid,
  output logic              ofm_pop
);

  localparam int unsigned WT_NUM = WT_DIM * WT_DIM;
  localparam int unsigned OW     = $clog2(MAX_OUTST) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WT,
    S_RUN,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       fm_sq_q;
  logic [AWIDTH-1:0] wt_base_q, ifm_base_q, ofm_base_q;
  logic [31:0]       wt_cnt_q, rd_cnt_q, wr_cnt_q;
  logic [OW-1:0]     outst_q, outst_d;
  logic              pref_w_q;

  logic fire, load_en, outst_ok;
  logic wt_cand, rd_cand, wr_cand;
  logic grant_w, grant_r;
  logic load_wt, load_rd, load_wr, load_read;
  logic job_start, resp_take;

  // Request port handshake and candidate selection
  always_comb begin
    fire      = req_valid & req_ready;
    load_en   = ~req_valid | fire;
    ofm_pop   = fire & req_write;
    outst_ok  = outst_q < OW'(MAX_OUTST);
    job_start = (state_q == S_IDLE) & start;

    wt_cand = (state_q == S_WT) & (wt_cnt_q < 32'(WT_NUM)) & outst_ok;
    rd_cand = (state_q == S_RUN) & (rd_cnt_q < fm_sq_q) & outst_ok;
    // The OFM word being popped this cycle is gone, so a pending write blocks the next one.
    wr_cand = (state_q == S_RUN) & (wr_cnt_q < fm_sq_q) & ofm_valid & ~(req_valid & req_write);

    grant_w = wr_cand & (~rd_cand | pref_w_q);
    grant_r = rd_cand & ~grant_w;

    load_wt   = load_en & wt_cand;
    load_rd   = load_en & grant_r;
    load_wr   = load_en & grant_w;
    load_read = load_wt | load_rd;
  end

  // Outstanding read credits: loads add, returns release, never below zero
  always_comb begin
    outst_d   = outst_q;
    resp_take = rresp_valid & (outst_q != '0);
    if (load_read && !resp_take) begin
      outst_d = outst_q + OW'(1);
    end else if (!load_read && resp_take) begin
      outst_d = outst_q - OW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WT;
      end
      S_WT: begin
        if ((wt_cnt_q == 32'(WT_NUM)) && load_en) state_d = S_RUN;
      end
      S_RUN: begin
        if ((rd_cnt_q == fm_sq_q) && (wr_cnt_q == fm_sq_q) &&
            (outst_q == '0) && !req_valid) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idle    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idle    <= (state_d == S_IDLE);
      done    <= (state_d == S_FIN);
    end
  end

  // Job parameters and progress counters; indices advance when a request is loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fm_sq_q    <= '0;
      wt_base_q  <= '0;
      ifm_base_q <= '0;
      ofm_base_q <= '0;
      wt_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      outst_q    <= '0;
      pref_w_q   <= 1'b1;
    end else if (job_start) begin
      fm_sq_q    <= 32'(fm_dim * fm_dim);
      wt_base_q  <= wt_base;
      ifm_base_q <= ifm_base;
      ofm_base_q <= ofm_base;
      wt_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      outst_q    <= '0;
      pref_w_q   <= 1'b1;
    end else begin
      outst_q <= outst_d;
      if (load_wt) wt_cnt_q <= wt_cnt_q + 32'd1;
      if (load_rd) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (load_wr) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (load_rd || load_wr) pref_w_q <= load_rd;
    end
  end

  // Request register: reloads only when empty or firing, otherwise held stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_write <= 1'b0;
    end else if (load_en) begin
      req_valid <= load_read | load_wr;
      if (load_wt) begin
        req_addr  <= wt_base_q + AWIDTH'(wt_cnt_q);
        req_write <= 1'b0;
      end else if (load_rd) begin
        req_addr  <= ifm_base_q + AWIDTH'(rd_cnt_q);
        req_write <= 1'b0;
      end else if (load_wr) begin
        req_addr  <= ofm_base_q + AWIDTH'(wr_cnt_q);
        req_write <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_opt_mem_sched.sv
// Scoreboard bench for conv2d_opt_mem_sched: directed jobs push expected requests,
// a negedge monitor pops and compares each fired request and models read returns.
module tb_conv2d_opt_mem_sched;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   fm_dim = '0;
  logic [AW-1:0] wt_base = '0, ifm_base = '0, ofm_base = '0;
  logic          req_ready = 1'b1;
  logic          rresp_valid = 1'b0;
  logic          ofm_valid = 1'b0;
  logic          idle, done, req_valid, req_write, ofm_pop;
  logic [AW-1:0] req_addr;

  conv2d_opt_mem_sched #(.AWIDTH(AW), .WT_DIM(3), .MAX_OUTST(8)) dut (
    .clk(clk), .rst(rst), .start(start), .fm_dim(fm_dim),
    .wt_base(wt_base), .ifm_base(ifm_base), .ofm_base(ofm_base),
    .idle(idle), .done(done), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .rresp_valid(rresp_valid),
    .ofm_valid(ofm_valid), .ofm_pop(ofm_pop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;
  int   fires = 0, done_cnt = 0, pending = 0;
  int   tok_given = 0, tok_used = 0;
  int   job_base = 0;
  bit   auto_resp = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a);
    exp_t e;
    e.w = w;
    e.a = a;
    q.push_back(e);
  endtask

  task automatic push_weights(input logic [AW-1:0] b);
    for (int i = 0; i < 9; i++) push(1'b0, b + AW'(i));
  endtask

  // Monitor: compare fired requests in order, count done pulses, return reads
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        pending = 0;
        rresp_valid = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (req_valid && req_ready) begin
          fires++;
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: got addr %0h write %0b, expected no request", req_addr, req_write);
          end else begin
            e = q.pop_front();
            check("req_write", 64'(req_write), 64'(e.w));
            check("req_addr", 64'(req_addr), 64'(e.a));
            check("ofm_pop", 64'(ofm_pop), 64'(e.w));
          end
          if (!req_write) pending++;
        end
        if (pending > 0 && (auto_resp || tok_given > tok_used)) begin
          rresp_valid = 1'b1;
          pending--;
          if (!auto_resp) tok_used++;
        end else begin
          rresp_valid = 1'b0;
        end
      end
    end
  end

  task automatic start_job(input logic [31:0] d, input logic [AW-1:0] wb,
                           input logic [AW-1:0] ib, input logic [AW-1:0] ob);
    fm_dim = d; wt_base = wb; ifm_base = ib; ofm_base = ob;
    job_base = fires;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fires(input int n);
    int t = 0;
    while ((fires - job_base) < n && t < 500) begin
      @(posedge clk);
      t++;
    end
    if ((fires - job_base) < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_fires: got %0d fires, expected %0d", fires - job_base, n);
    end
    #1;
  endtask

  task automatic wait_done(input string name, input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    check({name, "_queue_drained"}, 64'(q.size()), 64'(0));
    check({name, "_idle"}, 64'(idle), 64'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_req_valid", 64'(req_valid), 64'(0));
    check("rst_req_addr", 64'(req_addr), 64'(0));
    check("rst_req_write", 64'(req_write), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Job 1: fm_dim=2, reads first, then writes once OFM data is offered
    d0 = done_cnt;
    push_weights(32'h100);
    for (int i = 0; i < 4; i++) push(1'b0, 32'h2000 + AW'(i));
    for (int i = 0; i < 4; i++) push(1'b1, 32'h8000 + AW'(i));
    fm_dim = 2; wt_base = 32'h100; ifm_base = 32'h2000; ofm_base = 32'h8000;
    job_base = fires;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", 64'(req_valid), 64'(0));
    check("lat_cycle1_idle", 64'(idle), 64'(0));
    @(negedge clk);
    check("lat_cycle2_valid", 64'(req_valid), 64'(1));
    wait_fires(13);
    ofm_valid = 1'b1;
    wait_done("job1", d0);
    ofm_valid = 1'b0;

    // Job 2: backpressure mid-weights holds the request register
    d0 = done_cnt;
    ofm_valid = 1'b1;
    push_weights(32'h300);
    push(1'b1, 32'h9000);
    push(1'b0, 32'h4000);
    start_job(1, 32'h300, 32'h4000, 32'h9000);
    wait_fires(4);
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(req_valid), 64'(1));
      check("stall_addr", 64'(req_addr), 64'(32'h304));
    end
    @(posedge clk); #1;
    req_ready = 1'b1;
    wait_done("job2", d0);
    ofm_valid = 1'b0;

    // Job 3: returns withheld -> credit cap of 8, one return frees one read
    d0 = done_cnt;
    auto_resp = 1'b0;
    push_weights(32'h500);
    start_job(1, 32'h500, 32'h5000, 32'hA000);
    repeat (20) @(posedge clk);
    #1;
    check("outst_cap_fires", 64'(fires - job_base), 64'(8));
    tok_given++;
    repeat (10) @(posedge clk);
    #1;
    check("one_more_read", 64'(fires - job_base), 64'(9));
    push(1'b1, 32'hA000);
    push(1'b0, 32'h5000);
    ofm_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    auto_resp = 1'b1;
    wait_done("job3", d0);
    ofm_valid = 1'b0;

    // Job 4: writes and reads both eligible -> W,R,W,R alternation
    d0 = done_cnt;
    ofm_valid = 1'b1;
    push_weights(32'h700);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 32'hC000 + AW'(i));
      push(1'b0, 32'h6000 + AW'(i));
    end
    start_job(2, 32'h700, 32'h6000, 32'hC000);
    wait_done("job4", d0);
    ofm_valid = 1'b0;

    // Job 5: fm_dim=0 reads weights only; a start during WT is ignored
    d0 = done_cnt;
    push_weights(32'h900);
    start_job(0, 32'h900, 32'h7000, 32'hE000);
    wait_fires(3);
    fm_dim = 5; wt_base = 32'h1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("job5", d0);
    check("job5_fires", 64'(fires - job_base), 64'(9));

    // Job 6: reset mid-RUN aborts without a done pulse
    d0 = done_cnt;
    ofm_valid = 1'b1;
    push_weights(32'hB00);
    push(1'b1, 32'hF000);
    push(1'b0, 32'h1000);
    push(1'b1, 32'hF001);
    push(1'b0, 32'h1001);
    start_job(4, 32'hB00, 32'h1000, 32'hF000);
    wait_fires(12);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", 64'(idle), 64'(1));
    check("abort_req_valid", 64'(req_valid), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'(0));
    check("abort_still_idle", 64'(idle), 64'(1));
    check("abort_no_req", 64'(req_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
